tx_uart: RTL and testbench

- 8N1 asynchronous serial transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Bit period is programmable at runtime through baud_div.
- A host requests transmission with a start_tx pulse. The block reports busy (tx_started) and completion (tx_done).
- Sits on the TX side of the UART block, driving the serial pin directly.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_cnt.sv | 36 +++
 rtl/tx_uart.sv | 113 +++++++++++
 tb/tb_tx_uart.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame geometry and FSM states.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BAUD_W    = 16;
    localparam int unsigned IDX_W     = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter; bit_end_c marks the last cycle of each bit.
module uart_baud_cnt
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [BAUD_W-1:0] load_val,
    input  logic [BAUD_W-1:0] reload_val,
    output logic              bit_end_c
);

    logic [BAUD_W-1:0] cnt_q;
    logic [BAUD_W-1:0] cnt_d;

    assign bit_end_c = en && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? reload_val : cnt_q - BAUD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tx_uart.sv
// 8N1 serial transmitter with a runtime-programmable bit period.
module tx_uart
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BAUD_W-1:0] baud_div,
    input  logic              start_tx,
    input  logic [7:0]        data_in,
    output logic              tx_pin,
    output logic              tx_started,
    output logic              tx_done
);

    tx_state_e              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic                   tx_pin_q, tx_pin_d;
    logic                   tx_started_q, tx_started_d;
    logic                   tx_done_q, tx_done_d;
    logic                   baud_load_c;
    logic                   bit_end_c;

    uart_baud_cnt u_baud_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state_q != IDLE),
        .load       (baud_load_c),
        .load_val   (baud_div),
        .reload_val (baud_q),
        .bit_end_c  (bit_end_c)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        baud_d       = baud_q;
        tx_pin_d     = tx_pin_q;
        tx_started_d = tx_started_q;
        tx_done_d    = 1'b0;
        baud_load_c  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_pin_d = 1'b1;
                // Request and bit period are frozen here for the whole frame.
                if (start_tx) begin
                    shift_d      = data_in;
                    baud_d       = baud_div;
                    baud_load_c  = 1'b1;
                    state_d      = START;
                    tx_pin_d     = 1'b0;
                    tx_started_d = 1'b1;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_pin_d  = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d  = STOP;
                        tx_pin_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tx_pin_d  = shift_q[bit_idx_d];
                    end
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    state_d      = IDLE;
                    tx_pin_d     = 1'b1;
                    tx_started_d = 1'b0;
                    tx_done_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            baud_q       <= '0;
            tx_pin_q     <= 1'b1;
            tx_started_q <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            baud_q       <= baud_d;
            tx_pin_q     <= tx_pin_d;
            tx_started_q <= tx_started_d;
            tx_done_q    <= tx_done_d;
        end
    end

    assign tx_pin     = tx_pin_q;
    assign tx_started = tx_started_q;
    assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_tx_uart.sv
// Scoreboard bench for tx_uart: stimulus queues expected frames, a line monitor decodes and checks them.
module tb_tx_uart;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] baud_div = 16'd0;
    logic        start_tx = 1'b0;
    logic [7:0]  data_in = 8'd0;
    logic        tx_pin;
    logic        tx_started;
    logic        tx_done;

    tx_uart dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_div   (baud_div),
        .start_tx   (start_tx),
        .data_in    (data_in),
        .tx_pin     (tx_pin),
        .tx_started (tx_started),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         period;
        bit         b2b;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   frames_done = 0;
    int   frames_expected = 0;
    int   cyc = 0;
    int   last_done_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp_v);
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got pin/busy/done=%b expected %b", nm, cyc, got, exp_v);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp_v);
        vectors++;
        if (got != exp_v) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp_v);
        end
    endtask

    // Line monitor: a frame is a 0 start bit, 8 data bits LSB first, a 1 stop bit,
    // each exactly 'period' cycles, followed by tx_done on the next cycle boundary.
    exp_t cur;
    bit   in_frame = 1'b0;
    int   t = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
            chk("reset", {tx_pin, tx_started, tx_done}, 3'b100);
        end else if (!in_frame) begin
            if (tx_pin === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", {tx_pin, tx_started, tx_done}, 3'b100);
                end else begin
                    cur = exp_q.pop_front();
                    in_frame = 1'b1;
                    t = 0;
                    if (cur.b2b) chk_int("b2b_gap", cyc, last_done_cyc + 1);
                    chk("frame_start", {tx_pin, tx_started, tx_done}, 3'b010);
                end
            end else begin
                chk("idle", {tx_pin, tx_started, tx_done}, 3'b100);
            end
        end else begin
            t++;
            if (t < 10 * cur.period) begin
                int         idx;
                logic       b;
                logic [7:0] d;
                idx = t / cur.period;
                d   = cur.data;
                if (idx == 0)      b = 1'b0;
                else if (idx == 9) b = 1'b1;
                else               b = d[idx-1];
                chk($sformatf("frame_bit%0d_d%02h", idx, cur.data), {tx_pin, tx_started, tx_done}, {b, 2'b10});
            end else begin
                chk("frame_done", {tx_pin, tx_started, tx_done}, 3'b101);
                in_frame = 1'b0;
                frames_done++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (tx_started !== 1'b0 && guard < 700000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // Pulse start_tx for one edge, then scramble inputs to prove they were latched.
    task automatic issue(input logic [7:0] d, input logic [15:0] b);
        exp_t e;
        wait_idle();
        @(negedge clk);
        start_tx = 1'b1;
        data_in  = d;
        baud_div = b;
        e.data = d; e.period = int'(b) + 1; e.b2b = 1'b0;
        exp_q.push_back(e);
        frames_expected++;
        @(negedge clk);
        start_tx = 1'b0;
        data_in  = 8'($urandom);
        baud_div = 16'($urandom);
    endtask

    task automatic wait_frames(input int target, input int bound);
        int guard = 0;
        while (frames_done < target && guard < bound) begin
            @(negedge clk);
            guard++;
        end
        chk_int("frame_timeout", frames_done, target);
    endtask

    task automatic send(input logic [7:0] d, input logic [15:0] b);
        issue(d, b);
        wait_frames(frames_expected, 10 * (int'(b) + 1) + 20);
    endtask

    task automatic wait_done();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (tx_done !== 1'b1 && guard < 1000);
    endtask

    initial begin
        exp_t e;
        #1 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_hold", {tx_pin, tx_started, tx_done}, 3'b100);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);

        send(8'hA5, 16'd434);

        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            send(8'hFF ^ 8'(i), 16'($urandom_range(0, 3)));
        end

        // Start pulses while busy must be dropped.
        issue(8'h81, 16'd10);
        repeat (30) @(negedge clk);
        start_tx = 1'b1; data_in = 8'h3C;
        @(negedge clk);
        start_tx = 1'b0;
        wait_frames(frames_expected, 200);
        repeat (150) @(negedge clk);
        chk_int("busy_single_frame", frames_done, frames_expected);

        send(8'h55, 16'd0);

        // Held start_tx: frames back-to-back with one idle cycle between.
        wait_idle();
        @(negedge clk);
        baud_div = 16'd1; data_in = 8'h96; start_tx = 1'b1;
        e.data = 8'h96; e.period = 2; e.b2b = 1'b0;
        exp_q.push_back(e); frames_expected++;
        for (int k = 0; k < 2; k++) begin
            wait_done();
            data_in = 8'(8'h3A + 8'(k * 17));
            e.data = data_in; e.period = 2; e.b2b = 1'b1;
            exp_q.push_back(e); frames_expected++;
        end
        wait_done();
        start_tx = 1'b0;
        wait_frames(frames_expected, 100);

        // Reset during data bit 3.
        issue(8'hC3, 16'd5);
        repeat (27) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_immediate", {tx_pin, tx_started, tx_done}, 3'b100);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        frames_expected--;
        repeat (5) @(negedge clk);
        send(8'h5A, 16'd3);

        // Longest bit period: start bit plus part of bit 0, then abort.
        issue(8'hA5, 16'hFFFF);
        repeat (65536 + 20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_long", {tx_pin, tx_started, tx_done}, 3'b100);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        frames_expected--;
        repeat (20) @(negedge clk);

        chk_int("frames_total", frames_done, frames_expected);
        chk_int("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
